// File: rtl/accum_tile_sequencer.sv
// Sequences accumulator enables across K tiles of one output tile: tile_len-cycle
// bursts separated by GAP_CYCLES idle cycles, then a column-skew drain and a done pulse.
module accum_tile_sequencer #(
  parameter int SYS_COLS   = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_tile_len_i,
  input  logic [CNT_W-1:0] cfg_num_ktiles_i,
  input  logic             abort_i,
  output logic             acc_enable_o,
  output logic             acc_start_o,
  output logic             acc_last_o,
  output logic [CNT_W-1:0] k_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int WW = $clog2(SYS_COLS + GAP_CYCLES + 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [WW-1:0]    WONE     = WW'(1);
  localparam logic [WW-1:0]    GAP_LD   = WW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0]    DRAIN_LD = WW'(SYS_COLS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             start_q, start_d;
  logic             last_q, last_d;

  // Run counter counts down from tile_len-1, so the expiry test never needs tile_len+1.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          len_d = cfg_tile_len_i;
          num_d = cfg_num_ktiles_i;
          k_d   = '0;
          cnt_d = cfg_tile_len_i - ONE;
          if (cfg_tile_len_i == '0 || cfg_num_ktiles_i == '0) state_d = DONE;
          else                                               state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (k_q < num_q - ONE) begin
            state_d = GAP;
            wait_d  = GAP_LD;
          end else begin
            state_d = DRAIN;
            wait_d  = DRAIN_LD;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP: begin
        if (wait_q == '0) begin
          state_d = RUN;
          k_d     = k_q + ONE;
          cnt_d   = len_q - ONE;
        end else begin
          wait_d = wait_q - WONE;
        end
      end
      DRAIN: begin
        if (wait_q == '0) state_d = DONE;
        else              wait_d  = wait_q - WONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Cancel wins over everything, including a same-cycle acceptance.
    if (abort_i) begin
      state_d = IDLE;
      k_d     = '0;
    end
  end

  always_comb begin
    start_d = 1'b0;
    last_d  = 1'b0;
    if (!abort_i && state_q == RUN) begin
      start_d = (k_q == '0);
      last_d  = (k_q == num_q - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      wait_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      start_q <= start_d;
      last_q  <= last_d;
    end
  end

  assign cfg_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign acc_enable_o = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign acc_start_o  = start_q;
  assign acc_last_o   = last_q;
  assign k_idx_o      = k_q;

endmodule

// File: doc/accum_tile_sequencer.md
ACCUM_TILE_SEQUENCER -- requirements
Module: accum_tile_sequencer

Interface
REQ-001 Parameter SYS_COLS, default 4; systolic column count, used to size the drain wait for column-skewed read-out.
REQ-002 Parameter GAP_CYCLES, default 1, legal range 1..15; idle cycles with acc_enable low between consecutive K tiles.
REQ-003 Parameter CNT_W, default 8; width of the tile_len and num_ktiles fields.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_valid  input  1  job descriptor valid.
REQ-007 cfg_ready  output  1  sequencer can accept a descriptor.
REQ-008 cfg_tile_len  input  CNT_W  cycles of accumulator enable per K tile.
REQ-009 cfg_num_ktiles  input  CNT_W  number of K tiles accumulated into one output tile.
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 acc_enable  output  1  accumulator enable.
REQ-012 acc_start  output  1  first-K-tile flag (overwrite, no read-back), aligned to acc_enable delayed by one cycle.
REQ-013 acc_last  output  1  last-K-tile flag (emit result), aligned to acc_enable delayed by one cycle.
REQ-014 k_idx  output  CNT_W  index of the K tile currently being issued.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when a job's results have fully drained.

Function
REQ-017 The sequencer SHALL use states IDLE, RUN, GAP, DRAIN, DONE.
REQ-018 cfg_ready SHALL equal 1 only in IDLE; a descriptor SHALL be accepted on the cycle where cfg_valid && cfg_ready, with tile_len and num_ktiles latched.
REQ-019 If either latched field is 0, the accepted job SHALL go IDLE->DONE with acc_enable never asserted, and done SHALL pulse on the next cycle.
REQ-020 Otherwise IDLE->RUN; acc_enable SHALL be 1 for exactly tile_len consecutive cycles, starting the cycle after acceptance.
REQ-021 On RUN expiry, if k_idx < num_ktiles-1, the state SHALL go to GAP for GAP_CYCLES cycles with acc_enable=0, then return to RUN with k_idx incremented.
REQ-022 On RUN expiry of the final tile, the state SHALL go to DRAIN for SYS_COLS+1 cycles, then to DONE for one cycle (done=1), then to IDLE.
REQ-023 acc_start SHALL be 1 in every cycle where the previous cycle had acc_enable=1 with k_idx=0; otherwise 0.
REQ-024 acc_last SHALL be 1 in every cycle where the previous cycle had acc_enable=1 with k_idx=num_ktiles-1; otherwise 0.
REQ-025 When num_ktiles=1, acc_start and acc_last SHALL both be 1 for that tile's delayed window.
REQ-026 k_idx SHALL reset to 0 on acceptance, increment only on GAP->RUN, and never wrap within a job.
REQ-027 Internal counters SHALL be CNT_W bits; tile_len=2^CNT_W-1 and num_ktiles=2^CNT_W-1 SHALL sequence fully, with no overflow.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge, with acc_enable, acc_start, acc_last, done=0 and k_idx=0; no done pulse SHALL be issued.
REQ-029 abort has priority over cfg acceptance in the same cycle.
REQ-030 cfg_valid while busy SHALL be ignored, with no latch update.

Reset
REQ-031 On rst=1, the state SHALL be IDLE, with cfg_ready=1, acc_enable=0, acc_start=0, acc_last=0, k_idx=0, busy=0, done=0.
REQ-032 Reset asserted mid-job SHALL abandon the job identically to abort, and the first descriptor after reset SHALL be accepted normally.

Verification
REQ-033 tile_len=3, num_ktiles=1, accepted at cycle 0 -> acc_enable high at cycles 1-3; acc_start=acc_last=1 at cycles 2-4; drain cycles 4-8 (SYS_COLS=4); done at cycle 9; cfg_ready=1 at cycle 10.
REQ-034 tile_len=2, num_ktiles=3, GAP_CYCLES=1 -> enable at cycles 1-2, 4-5, 7-8; acc_start only at cycles 2-3; acc_last only at cycles 8-9; k_idx reads 0, 1, 2; done at cycle 14.
REQ-035 tile_len=0 or num_ktiles=0 -> acc_enable never asserts; done at cycle 1.
REQ-036 abort at cycle 4 during the REQ-034 job -> all outputs 0 from cycle 5, no done; a new descriptor at cycle 6 is accepted.
REQ-037 cfg_valid held high through a job -> exactly one acceptance per DONE->IDLE return; descriptor field changes while busy have no effect.
REQ-038 rst pulsed at cycle 3 of the REQ-034 job -> REQ-031 values from cycle 4.
